// File: rtl/paddle_pkg.sv
// Shared types and saturating arithmetic helpers for the paddle emulator.
// Arithmetic helpers work on 32-bit unsigned values, so intermediate sums
// never wrap for any supported position width.
package paddle_pkg;

  typedef enum logic [1:0] {
    DIR_HOLD,
    DIR_UP,
    DIR_DOWN
  } dir_t;

  typedef enum logic {
    MODE_DIGITAL,
    MODE_ANALOG
  } mode_t;

  // Add with an upper clamp; the sum is formed wide so it cannot wrap.
  function automatic int unsigned clamp_add(input int unsigned pos,
                                            input int unsigned step,
                                            input int unsigned max);
    int unsigned sum;
    sum = pos + step;
    return (sum > max) ? max : sum;
  endfunction

  // Subtract with a floor of zero.
  function automatic int unsigned clamp_sub(input int unsigned pos,
                                            input int unsigned step);
    return (pos > step) ? (pos - step) : 32'd0;
  endfunction

  // Limit an absolute position to the legal range.
  function automatic int unsigned clamp_max(input int unsigned pos,
                                            input int unsigned max);
    return (pos > max) ? max : pos;
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle: per-frame position update (digital stepping with hold
// acceleration, or analog absolute), the line-countdown capture register,
// and the registered paddle-timing pin that goes high when the countdown
// reaches zero.
module paddle_channel
  import paddle_pkg::*;
#(
  parameter int unsigned POS_W        = 9,
  parameter int unsigned POS_MAX      = 255,
  parameter int unsigned CENTER       = 128,
  parameter int unsigned STEP_SLOW    = 5,
  parameter int unsigned STEP_FAST    = 8,
  parameter int unsigned ACCEL_FRAMES = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             vs_rise,
  input  logic             hs_rise,
  input  logic             speed_sel,
  input  mode_t            mode,
  input  logic             up,
  input  logic             down,
  input  logic [POS_W-1:0] analog_pos,
  output logic [POS_W-1:0] pos,
  output logic             pad_pin
);

  localparam int unsigned HELD_W = $clog2(ACCEL_FRAMES + 1);
  localparam logic [HELD_W-1:0] ACCEL_LIM = HELD_W'(ACCEL_FRAMES);

  logic [POS_W-1:0]  cap;
  logic [HELD_W-1:0] held_cnt;
  dir_t              last_dir;

  logic [POS_W-1:0]  pos_nxt;
  logic [POS_W-1:0]  cap_nxt;
  logic [HELD_W-1:0] held_nxt;
  dir_t              last_dir_nxt;
  dir_t              dir;
  int unsigned       step;

  // Decode the joystick request and choose the step, doubled once held long enough.
  always_comb begin
    dir  = DIR_HOLD;
    step = speed_sel ? STEP_FAST : STEP_SLOW;
    if (up && !down) begin
      dir = DIR_UP;
    end else if (down && !up) begin
      dir = DIR_DOWN;
    end
    if (held_cnt >= ACCEL_LIM) begin
      step = step << 1;
    end
  end

  // Next-state: a frame start captures and updates; a line start counts the capture down.
  always_comb begin
    pos_nxt      = pos;
    cap_nxt      = cap;
    held_nxt     = held_cnt;
    last_dir_nxt = last_dir;
    if (vs_rise) begin
      cap_nxt = pos;
      if (mode == MODE_ANALOG) begin
        pos_nxt      = POS_W'(clamp_max(32'(analog_pos), POS_MAX));
        held_nxt     = '0;
        last_dir_nxt = DIR_HOLD;
      end else begin
        case (dir)
          DIR_UP:   pos_nxt = POS_W'(clamp_sub(32'(pos), step));
          DIR_DOWN: pos_nxt = POS_W'(clamp_add(32'(pos), step, POS_MAX));
          default:  pos_nxt = pos;
        endcase
        if ((dir != DIR_HOLD) && (dir == last_dir)) begin
          held_nxt = (held_cnt >= ACCEL_LIM) ? held_cnt : held_cnt + 1'b1;
        end else begin
          held_nxt = '0;
        end
        last_dir_nxt = dir;
      end
    end else if (hs_rise && (cap != '0)) begin
      cap_nxt = cap - 1'b1;
    end
  end

  // Channel state registers; the pin reflects the countdown one cycle late.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pos      <= POS_W'(CENTER);
      cap      <= '0;
      held_cnt <= '0;
      last_dir <= DIR_HOLD;
      pad_pin  <= 1'b1;
    end else begin
      pos      <= pos_nxt;
      cap      <= cap_nxt;
      held_cnt <= held_nxt;
      last_dir <= last_dir_nxt;
      pad_pin  <= (cap == '0);
    end
  end

endmodule

// File: rtl/paddle_emulator.sv
// Multi-channel paddle emulator top: detects sync edges from the game chip,
// emits a frame tick, and fans the frame/line events out to independent
// per-paddle channels whose timing pins drive LPin/RPin.
module paddle_emulator
  import paddle_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned POS_W        = 9,
  parameter int unsigned POS_MAX      = 255,
  parameter int unsigned CENTER       = 128,
  parameter int unsigned STEP_SLOW    = 5,
  parameter int unsigned STEP_FAST    = 8,
  parameter int unsigned ACCEL_FRAMES = 8
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      vs,
  input  logic                      hs,
  input  logic                      speed_sel,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       up,
  input  logic [CHANNELS-1:0]       down,
  input  logic [CHANNELS*POS_W-1:0] analog_pos,
  output logic [CHANNELS*POS_W-1:0] pos_out,
  output logic [CHANNELS-1:0]       pad_pin,
  output logic                      frame_tick
);

  logic vs_q;
  logic hs_q;
  logic vs_rise;
  logic hs_rise;

  assign vs_rise = vs & ~vs_q;
  assign hs_rise = hs & ~hs_q;

  // Sync history for edge detection and the registered frame pulse.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vs_q       <= 1'b0;
      hs_q       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= vs;
      hs_q       <= hs;
      frame_tick <= vs_rise;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    paddle_channel #(
      .POS_W        (POS_W),
      .POS_MAX      (POS_MAX),
      .CENTER       (CENTER),
      .STEP_SLOW    (STEP_SLOW),
      .STEP_FAST    (STEP_FAST),
      .ACCEL_FRAMES (ACCEL_FRAMES)
    ) u_channel (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .vs_rise    (vs_rise),
      .hs_rise    (hs_rise),
      .speed_sel  (speed_sel),
      .mode       (mode_t'(mode[gi])),
      .up         (up[gi]),
      .down       (down[gi]),
      .analog_pos (analog_pos[gi*POS_W +: POS_W]),
      .pos        (pos_out[gi*POS_W +: POS_W]),
      .pad_pin    (pad_pin[gi])
    );
  end

endmodule

// File: tb/tb_paddle_emulator.sv
// Directed bench for paddle_emulator with two channels and default parameters.
module tb_paddle_emulator;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vs;
  logic        hs;
  logic        speed_sel;
  logic [1:0]  mode;
  logic [1:0]  up;
  logic [1:0]  down;
  logic [17:0] analog_pos;
  logic [17:0] pos_out;
  logic [1:0]  pad_pin;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  int exp_down [15] = '{121, 129, 137, 145, 153, 161, 169, 177, 185,
                        201, 217, 233, 249, 255, 255};

  always #5 clk_sys = ~clk_sys;

  paddle_emulator #(
    .CHANNELS     (2),
    .POS_W        (9),
    .POS_MAX      (255),
    .CENTER       (128),
    .STEP_SLOW    (5),
    .STEP_FAST    (8),
    .ACCEL_FRAMES (8)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .vs         (vs),
    .hs         (hs),
    .speed_sel  (speed_sel),
    .mode       (mode),
    .up         (up),
    .down       (down),
    .analog_pos (analog_pos),
    .pos_out    (pos_out),
    .pad_pin    (pad_pin),
    .frame_tick (frame_tick)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic vs_val, input logic hs_val);
    vs = vs_val;
    hs = hs_val;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic pulse_vs();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic pulse_hs();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    vs         = 1'b0;
    hs         = 1'b0;
    speed_sel  = 1'b0;
    mode       = 2'b00;
    up         = 2'b00;
    down       = 2'b00;
    analog_pos = '0;
    tick();
    tick();
    checkOutput("reset_pos0", pos_out[8:0], 128);
    checkOutput("reset_pos1", pos_out[17:9], 128);
    checkOutput("reset_pad", pad_pin, 2'b11);
    checkOutput("reset_tick", frame_tick, 0);
    reset = 1'b0;
    tick();

    // ch0 up, slow steps
    $display("[TB] digital up, slow");
    up = 2'b01;
    applyStimulus(1'b1, 1'b0);
    checkOutput("tick_high", frame_tick, 1);
    checkOutput("up_f1", pos_out[8:0], 123);
    applyStimulus(1'b0, 1'b0);
    checkOutput("tick_low", frame_tick, 0);
    pulse_vs();
    checkOutput("up_f2", pos_out[8:0], 118);
    pulse_vs();
    checkOutput("up_f3", pos_out[8:0], 113);
    checkOutput("ch1_idle", pos_out[17:9], 128);
    checkOutput("pads_low", pad_pin, 2'b00);
    for (int i = 0; i < 117; i++) pulse_hs();
    checkOutput("cap0_117", pad_pin[0], 0);
    pulse_hs();
    checkOutput("cap0_118", pad_pin[0], 1);

    // ch0 down, fast steps, acceleration and clamp
    $display("[TB] digital down, fast, accel");
    up        = 2'b00;
    down      = 2'b01;
    speed_sel = 1'b1;
    for (int k = 0; k < 15; k++) begin
      pulse_vs();
      checkOutput($sformatf("down_f%0d", k + 1), pos_out[8:0], exp_down[k]);
    end
    down = 2'b00;
    pulse_vs();
    checkOutput("release_hold", pos_out[8:0], 255);
    up = 2'b01;
    pulse_vs();
    checkOutput("accel_reset", pos_out[8:0], 247);
    up = 2'b00;

    // ch1 analog, countdown of 3 lines
    $display("[TB] line countdown");
    mode             = 2'b10;
    analog_pos[17:9] = 9'd3;
    pulse_vs();
    checkOutput("analog3", pos_out[17:9], 3);
    pulse_vs();
    checkOutput("cap1_3_low", pad_pin[1], 0);
    pulse_hs();
    pulse_hs();
    checkOutput("cap1_after2", pad_pin[1], 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("pad_lag", pad_pin[1], 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("pad_rise", pad_pin[1], 1);
    pulse_hs();
    pulse_hs();
    checkOutput("pad_stays", pad_pin[1], 1);
    checkOutput("ch0_steady", pos_out[8:0], 247);

    // vs and hs together: capture wins
    $display("[TB] simultaneous vs/hs");
    analog_pos[17:9] = 9'd5;
    pulse_vs();
    checkOutput("analog5", pos_out[17:9], 5);
    analog_pos[17:9] = 9'd2;
    applyStimulus(1'b1, 1'b1);
    checkOutput("both_tick", frame_tick, 1);
    checkOutput("both_pos", pos_out[17:9], 2);
    applyStimulus(1'b0, 1'b0);
    checkOutput("both_tick_once", frame_tick, 0);
    for (int i = 0; i < 4; i++) pulse_hs();
    checkOutput("cap5_after4", pad_pin[1], 0);
    pulse_hs();
    checkOutput("cap5_after5", pad_pin[1], 1);

    // analog clamp and mid-frame sampling
    $display("[TB] analog clamp");
    analog_pos[17:9] = 9'd300;
    pulse_vs();
    checkOutput("analog_clamp", pos_out[17:9], 255);
    analog_pos[17:9] = 9'd50;
    up = 2'b01;
    tick();
    tick();
    tick();
    checkOutput("midframe_pos1", pos_out[17:9], 255);
    checkOutput("midframe_pos0", pos_out[8:0], 247);
    up = 2'b00;
    pulse_vs();
    checkOutput("analog50", pos_out[17:9], 50);
    checkOutput("ch0_hold", pos_out[8:0], 247);

    // reset mid-frame
    $display("[TB] reset mid-frame");
    up = 2'b01;
    applyStimulus(1'b1, 1'b0);
    checkOutput("pre_reset_tick", frame_tick, 1);
    reset = 1'b1;
    vs    = 1'b0;
    #2;
    checkOutput("mid_reset_pos0", pos_out[8:0], 128);
    checkOutput("mid_reset_pos1", pos_out[17:9], 128);
    checkOutput("mid_reset_pad", pad_pin, 2'b11);
    checkOutput("mid_reset_tick", frame_tick, 0);
    tick();
    reset     = 1'b0;
    speed_sel = 1'b0;
    mode      = 2'b00;
    up        = 2'b01;
    tick();
    pulse_vs();
    checkOutput("post_reset_pos0", pos_out[8:0], 123);
    checkOutput("post_reset_pos1", pos_out[17:9], 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
